// File: rtl/dm_ptr_lut_pkg.sv
// dm_lut_pkg: pointer operation encoding and default table geometry shared with decode
package dm_lut_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, POST_INC = 2'd1, POST_DEC = 2'd2, PRE_INC = 2'd3} ptr_op_t;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_ADDR_W = 8;
endpackage

// File: rtl/dm_ptr_lut_if.sv
// dm_ptr_lut_if: decode-side access, load and address bundle for the pointer table
interface dm_ptr_lut_if
  import dm_lut_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic acc_en;
  logic [SEL_W-1:0] sel;
  ptr_op_t op;
  logic bypass;
  logic [ADDR_W-1:0] raw_adr;
  logic wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [ADDR_W-1:0] wr_data;
  logic [ADDR_W-1:0] dm_adr;
  logic wrap;
  modport master (output acc_en, sel, op, bypass, raw_adr, wr_en, wr_sel, wr_data, input dm_adr, wrap);
  modport slave (input acc_en, sel, op, bypass, raw_adr, wr_en, wr_sel, wr_data, output dm_adr, wrap);
endinterface

// File: rtl/dm_ptr_lut_entry.sv
// dm_ptr_entry: one pointer register with load, step up/down and wrap detect
module dm_ptr_entry #(
  parameter int ADDR_W = 8,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned INIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
  input  logic dec,
  input  logic ld,
  input  logic [ADDR_W-1:0] ld_data,
  output logic [ADDR_W-1:0] q,
  output logic wrapped
);
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(STRIDE);
  logic [ADDR_W:0] inc_v, dec_v;
  logic [ADDR_W-1:0] nxt;
  // the extra MSB is the carry on increment and the borrow on decrement
  always_comb begin
    inc_v = {1'b0, q} + STEP;
    dec_v = {1'b0, q} - STEP;
    nxt = dec ? dec_v[ADDR_W-1:0] : inc_v[ADDR_W-1:0];
    wrapped = dec ? dec_v[ADDR_W] : inc_v[ADDR_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= ADDR_W'(INIT);
    else if (ld) q <= ld_data;
    else if (upd) q <= nxt;
endmodule

// File: rtl/dm_ptr_lut.sv
// dm_ptr_lut: programmable data-memory pointer table with post/pre-step addressing
module dm_ptr_lut
  import dm_lut_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int unsigned STRIDE = 1
) (
  input logic clk,
  input logic rst_n,
  dm_ptr_lut_if.slave bus
);
  localparam int N = 2 ** SEL_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  logic [ADDR_W-1:0] q [N];
  logic [N-1:0] wrapped, upd, ld;
  logic step, hit, wrap_q;
  assign step = bus.acc_en && !bus.bypass && bus.op != HOLD;
  for (genvar e = 0; e < N; e++) begin : g_ent
    assign upd[e] = step && bus.sel == SEL_W'(e);
    assign ld[e] = bus.wr_en && bus.wr_sel == SEL_W'(e);
    dm_ptr_entry #(.ADDR_W(ADDR_W), .STRIDE(STRIDE), .INIT(e)) u_ent (
      .clk(clk),
      .rst_n(rst_n),
      .upd(upd[e]),
      .dec(bus.op == POST_DEC),
      .ld(ld[e]),
      .ld_data(bus.wr_data),
      .q(q[e]),
      .wrapped(wrapped[e])
    );
  end
  // a load to the stepped entry overrides the step, so its wrap is dropped
  assign hit = step && wrapped[bus.sel] && !ld[bus.sel];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= hit;
  assign bus.wrap = wrap_q;
  assign bus.dm_adr = bus.bypass ? bus.raw_adr : bus.op == PRE_INC ? q[bus.sel] + STEP : q[bus.sel];
endmodule

// File: tb/tb_dm_ptr_lut.sv
// tb_dm_ptr_lut: directed checks of addressing, stepping, wrap, collisions and async reset
module tb_dm_ptr_lut;
  import dm_lut_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  dm_ptr_lut_if #(.SEL_W(2), .ADDR_W(8)) b ();
  dm_ptr_lut #(.SEL_W(2), .ADDR_W(8), .STRIDE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;

  task automatic idle();
    b.acc_en = 0; b.sel = 0; b.op = HOLD; b.bypass = 0; b.raw_adr = 0;
    b.wr_en = 0; b.wr_sel = 0; b.wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int s, output logic [7:0] v);
    b.sel = 2'(s); b.op = HOLD; b.bypass = 0;
    #1 v = b.dm_adr;
  endtask

  task automatic load(input int s, input logic [7:0] d);
    b.wr_en = 1; b.wr_sel = 2'(s); b.wr_data = d;
    tick();
    b.wr_en = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      vectors++;
      if (v !== 8'(i)) begin errors++; $display("FAIL reset_entry%0d got %h want %h", i, v, 8'(i)); end
    end
    vectors++;
    if (b.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", b.wrap); end
  endtask

  task automatic test_bypass();
    logic [7:0] v;
    b.bypass = 1; b.raw_adr = 8'hA5; b.acc_en = 1; b.op = POST_INC; b.sel = 0;
    #1 vectors++;
    if (b.dm_adr !== 8'hA5) begin errors++; $display("FAIL bypass_adr got %h want a5", b.dm_adr); end
    tick();
    idle();
    rd(0, v);
    vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL bypass_untouched got %h want 00", v); end
  endtask

  task automatic test_post_inc();
    logic [7:0] v;
    load(2, 8'h40);
    b.sel = 2; b.acc_en = 1; b.op = POST_INC;
    for (int k = 0; k < 3; k++) begin
      #1 vectors++;
      if (b.dm_adr !== 8'h40 + 8'(k)) begin errors++; $display("FAIL post_inc_%0d got %h want %h", k, b.dm_adr, 8'h40 + 8'(k)); end
      tick();
    end
    idle();
    rd(2, v);
    vectors++;
    if (v !== 8'h43) begin errors++; $display("FAIL post_inc_final got %h want 43", v); end
  endtask

  task automatic test_pre_inc();
    logic [7:0] v;
    load(1, 8'h10);
    b.sel = 1; b.acc_en = 1; b.op = PRE_INC;
    #1 vectors++;
    if (b.dm_adr !== 8'h11) begin errors++; $display("FAIL pre_inc_adr got %h want 11", b.dm_adr); end
    tick();
    idle();
    rd(1, v);
    vectors++;
    if (v !== 8'h11) begin errors++; $display("FAIL pre_inc_entry got %h want 11", v); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    load(3, 8'hFF);
    b.sel = 3; b.acc_en = 1; b.op = POST_INC;
    tick();
    idle();
    vectors++;
    if (b.wrap !== 1'b1) begin errors++; $display("FAIL wrap_inc_pulse got %b want 1", b.wrap); end
    rd(3, v);
    vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL wrap_inc_entry got %h want 00", v); end
    tick();
    vectors++;
    if (b.wrap !== 1'b0) begin errors++; $display("FAIL wrap_inc_clear got %b want 0", b.wrap); end
    b.sel = 0; b.acc_en = 1; b.op = POST_DEC;
    tick();
    idle();
    vectors++;
    if (b.wrap !== 1'b1) begin errors++; $display("FAIL wrap_dec_pulse got %b want 1", b.wrap); end
    rd(0, v);
    vectors++;
    if (v !== 8'hFF) begin errors++; $display("FAIL wrap_dec_entry got %h want ff", v); end
    tick();
    vectors++;
    if (b.wrap !== 1'b0) begin errors++; $display("FAIL wrap_dec_clear got %b want 0", b.wrap); end
  endtask

  task automatic test_collision();
    logic [7:0] v;
    load(1, 8'hFF);
    b.sel = 1; b.acc_en = 1; b.op = POST_INC;
    b.wr_en = 1; b.wr_sel = 1; b.wr_data = 8'h80;
    tick();
    idle();
    vectors++;
    if (b.wrap !== 1'b0) begin errors++; $display("FAIL coll_same_wrap got %b want 0", b.wrap); end
    rd(1, v);
    vectors++;
    if (v !== 8'h80) begin errors++; $display("FAIL coll_same_entry got %h want 80", v); end
    b.sel = 0; b.acc_en = 1; b.op = POST_INC;
    b.wr_en = 1; b.wr_sel = 1; b.wr_data = 8'h90;
    tick();
    idle();
    vectors++;
    if (b.wrap !== 1'b1) begin errors++; $display("FAIL coll_diff_wrap got %b want 1", b.wrap); end
    rd(0, v);
    vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL coll_diff_entry0 got %h want 00", v); end
    rd(1, v);
    vectors++;
    if (v !== 8'h90) begin errors++; $display("FAIL coll_diff_entry1 got %h want 90", v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    load(0, 8'hFE);
    b.sel = 0; b.acc_en = 1; b.op = POST_INC;
    tick();
    tick();
    vectors++;
    if (b.wrap !== 1'b1) begin errors++; $display("FAIL areset_pre_wrap got %b want 1", b.wrap); end
    @(negedge clk);
    rst_n = 0;
    #1 vectors++;
    if (b.wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap got %b want 0", b.wrap); end
    b.acc_en = 0;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      vectors++;
      if (v !== 8'(i)) begin errors++; $display("FAIL areset_entry%0d got %h want %h", i, v, 8'(i)); end
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    rd(0, v);
    vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL areset_after got %h want 00", v); end
  endtask

  initial begin
    idle();
    #12 rst_n = 1;
    tick();
    test_reset();
    test_bypass();
    test_post_inc();
    test_pre_inc();
    test_wrap();
    test_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
